// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DBG = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way winner select: round-robin pointer, plus an owner lock
// when DMEM_ARB_LOCK_EN is defined.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  req_id_t            prio_ptr_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic               lock_active_i,
    input  req_id_t            lock_id_i,
`endif
    output logic [NUM_REQ-1:0] gnt_o,
    output req_id_t            gnt_id_o,
    output logic               gnt_valid_o
);

    logic [NUM_REQ-1:0] cand;

    always_comb begin
        cand = req_valid_i;
`ifdef DMEM_ARB_LOCK_EN
        // A held lock hides the other requester entirely, even if it has priority.
        if (lock_active_i) begin
            cand = req_valid_i & (NUM_REQ'(1) << lock_id_i);
        end
`endif
        if (cand == 2'b11) begin
            gnt_id_o = prio_ptr_i;
        end else if (cand[REQ_DBG]) begin
            gnt_id_o = REQ_DBG;
        end else begin
            gnt_id_o = REQ_CPU;
        end
        gnt_valid_o = |cand;
        gnt_o       = gnt_valid_o ? (NUM_REQ'(1) << gnt_id_o) : '0;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU and loader/debug requesters.
// Define DMEM_ARB_LOCK_EN to add req_lock for read-modify-write ownership.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEMORY_WIDTH = 256,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_we,
    input  logic [ADDR_W-1:0]  req_addr0,
    input  logic [ADDR_W-1:0]  req_addr1,
    input  logic [DATA_W-1:0]  req_wdata0,
    input  logic [DATA_W-1:0]  req_wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] req_lock,
`endif
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wd,
    input  logic [DATA_W-1:0]  mem_rd
);

    // One extra bit keeps the compare correct even when the depth needs all ADDR_W bits.
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DMEMORY_WIDTH);

    state_e             state_q;
    req_id_t            prio_q;
    req_id_t            win_q;
    logic               in_range_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wd_q;

    logic [NUM_REQ-1:0] gnt;
    req_id_t            gnt_id;
    logic               gnt_valid;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_in_range;

`ifdef DMEM_ARB_LOCK_EN
    logic    lock_active_q;
    req_id_t lock_id_q;
`endif

    rr_arb2 u_rr_arb2 (
        .req_valid_i   (req_valid),
        .prio_ptr_i    (prio_q),
`ifdef DMEM_ARB_LOCK_EN
        .lock_active_i (lock_active_q),
        .lock_id_i     (lock_id_q),
`endif
        .gnt_o         (gnt),
        .gnt_id_o      (gnt_id),
        .gnt_valid_o   (gnt_valid)
    );

    always_comb begin
        sel_we       = req_we[gnt_id];
        sel_addr     = (gnt_id == REQ_DBG) ? req_addr1 : req_addr0;
        sel_wdata    = (gnt_id == REQ_DBG) ? req_wdata1 : req_wdata0;
        sel_in_range = {1'b0, sel_addr} < DepthW;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio_q      <= REQ_CPU;
            win_q       <= REQ_CPU;
            in_range_q  <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_active_q <= 1'b0;
            lock_id_q     <= REQ_CPU;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q     <= ACCESS;
                        win_q       <= gnt_id;
                        in_range_q  <= sel_in_range;
                        req_ready_q <= gnt;
                        mem_we_q    <= sel_we & sel_in_range;
                        mem_addr_q  <= sel_addr;
                        mem_wd_q    <= sel_wdata;
`ifdef DMEM_ARB_LOCK_EN
                        lock_active_q <= req_lock[gnt_id];
                        lock_id_q     <= gnt_id;
`endif
                    end
                end
                ACCESS: begin
                    // mem_rd is the pre-write value: the memory commits a store on this edge.
                    state_q     <= RESP;
                    req_ready_q <= '0;
                    rsp_valid_q <= req_ready_q;
                    rsp_rdata_q <= in_range_q ? mem_rd : '0;
                    rsp_err_q   <= ~in_range_q;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wd_q    <= '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= '0;
                    prio_q      <= ~win_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-schedule reference model.
module tb_dmem_port_arbiter;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_we;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DMEMORY_WIDTH (DEPTH),
        .DATA_W        (32),
        .ADDR_W        (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Memory model: combinational read, write on posedge, poke port for preload.
    logic [31:0] ram [0:DEPTH-1];
    logic        poke_en;
    logic [7:0]  poke_a;
    logic [31:0] poke_d;

    assign mem_rd = (mem_addr < DEPTH) ? ram[mem_addr[7:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (mem_we) ram[mem_addr[7:0]] <= mem_wd;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: one transaction in flight, latched at edge p_lat.
    int          cyc = 0;
    bit          pend, prio, p_id, p_we, p_inr, lock_on, lock_id;
    int          p_lat;
    logic [31:0] p_addr, p_wd;
    logic [31:0] shadow [0:DEPTH-1];

    logic [1:0]  e_ready, e_rsp;
    logic        e_we, e_err;
    logic [31:0] e_addr, e_wd, e_rdata;
    bit          chk_data;

    logic [31:0] last_rdata;
    logic        last_err;
    int          we_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] v;
        bit w;
        @(posedge clk);
        #1;
        cyc++;
        e_ready = '0; e_rsp = '0; e_we = 1'b0; e_addr = '0; e_wd = '0; chk_data = 1'b0;
        if (pend && cyc == p_lat + 1) begin
            e_rdata = p_inr ? shadow[p_addr[7:0]] : 32'h0;
            e_err   = !p_inr;
            if (p_we && p_inr) shadow[p_addr[7:0]] = p_wd;
        end
        if (!reset) begin
            pend = 0; prio = 0; lock_on = 0;
            chk_data = 1'b1; e_rdata = '0; e_err = 1'b0;
        end else if (pend) begin
            if (cyc == p_lat + 1) begin
                e_rsp    = 2'b01 << p_id;
                chk_data = 1'b1;
            end else begin
                prio = !p_id;
                pend = 0;
            end
        end else begin
            v = req_valid;
`ifdef DMEM_ARB_LOCK_EN
            if (lock_on) v = v & (2'b01 << lock_id);
`endif
            if (v != 2'b00) begin
                w      = (v == 2'b11) ? prio : v[1];
                pend   = 1;
                p_lat  = cyc;
                p_id   = w;
                p_we   = req_we[w];
                p_addr = w ? req_addr1 : req_addr0;
                p_wd   = w ? req_wdata1 : req_wdata0;
                p_inr  = (p_addr < DEPTH);
`ifdef DMEM_ARB_LOCK_EN
                lock_on = req_lock[w];
                lock_id = w;
`endif
                e_ready = 2'b01 << w;
                e_we    = p_we && p_inr;
                e_addr  = p_addr;
                e_wd    = p_wd;
            end
        end
        check_eq("req_ready", req_ready, e_ready);
        check_eq("rsp_valid", rsp_valid, e_rsp);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wd", mem_wd, e_wd);
        if (chk_data) begin
            check_eq("rsp_rdata", rsp_rdata, e_rdata);
            check_eq("rsp_err", rsp_err, e_err);
        end
        if (rsp_valid != 2'b00) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        if (mem_we) we_cnt++;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic do_req(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        req_valid[id] = 1'b1;
        req_we[id]    = we;
        if (id) begin req_addr1 = addr; req_wdata1 = wd; end
        else begin req_addr0 = addr; req_wdata0 = wd; end
        do begin
            tick();
            n++;
        end while (req_ready[id] !== 1'b1 && n < 20);
        check_eq("req_granted", 64'(n < 20), 64'd1);
        req_valid[id] = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, DEPTH - 1));
        if (r == 8) return 32'($urandom_range(DEPTH, DEPTH + 4));
        return $urandom;
    endfunction

    logic [1:0]  grants [$];
    int          rsp_cnt [2];
    logic [31:0] r0;

    initial begin
        reset = 1'b0; req_valid = '0; req_we = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
        req_lock = '0;
`endif
        pend = 0; prio = 0; lock_on = 0; lock_id = 0; p_lat = 0;
        poke_en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            poke_a    = i[7:0];
            poke_d    = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            shadow[i] = poke_d;
            @(posedge clk);
            #1;
        end
        poke_en = 1'b0;
        tick();
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;

        // Single load of a preloaded word.
        req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'd5;
        tick();
        check_eq("ld_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();
        check_eq("ld_rsp_valid", rsp_valid, 2'b01);
        check_eq("ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("ld_err", rsp_err, 1'b0);
        tick();

        // Store then load through requester 1.
        we_cnt = 0;
        do_req(1'b1, 1'b1, 32'd10, 32'h1234_5678);
        check_eq("st_we_cycles", we_cnt, 1);
        do_req(1'b1, 1'b0, 32'd10, 32'h0);
        check_eq("st_ld_rdata", last_rdata, 32'h1234_5678);

        // Out-of-range store must not touch memory (a wrapped write would hit word 0).
        r0 = ram[0];
        we_cnt = 0;
        do_req(1'b0, 1'b1, 32'd256, 32'hFFFF_FFFF);
        check_eq("oor_we_cycles", we_cnt, 0);
        check_eq("oor_err", last_err, 1'b1);
        check_eq("oor_rdata", last_rdata, 32'h0);
        check_eq("oor_mem", ram[0], r0);

        // Contention: both requesters valid continuously.
        apply_reset();
        req_valid = 2'b11; req_we = 2'b00; req_addr0 = 32'd1; req_addr1 = 32'd2;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (req_ready != 2'b00) grants.push_back(req_ready);
            if (rsp_valid[0]) rsp_cnt[0]++;
            if (rsp_valid[1]) rsp_cnt[1]++;
        end
        req_valid = 2'b00;
        tick();
        check_eq("cont_ngrants", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) begin
            check_eq("cont_order", grants[k], (k % 2 == 1) ? 2'b10 : 2'b01);
        end
        check_eq("cont_rsp0", rsp_cnt[0], 2);
        check_eq("cont_rsp1", rsp_cnt[1], 2);

        // Reset during ACCESS drops the transaction and clears priority.
        do_req(1'b0, 1'b0, 32'd3, 32'h0);
        req_valid = 2'b11;
        tick();
        check_eq("mid_ready_pre", req_ready, 2'b10);
        reset = 1'b0;
        tick();
        check_eq("mid_rsp_dropped", rsp_valid, 2'b00);
        reset = 1'b1;
        tick();
        check_eq("mid_regrant", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // Lock: requester 0 keeps ownership across a turn where requester 1 has priority.
        apply_reset();
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b01;
        tick();
        check_eq("lock_first", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        tick();
        tick();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_lock[0] = 1'b0;
        req_addr0 = 32'd7; req_wdata0 = 32'hCAFE_F00D;
        tick();
        check_eq("lock_owner_again", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        check_eq("lock_released", req_ready, 2'b10);
        req_valid = 2'b00;
        tick();
        tick();
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || e_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_we[i]    = 1'($urandom_range(0, 1));
                    if (i == 0) begin req_addr0 = rand_addr(); req_wdata0 = $urandom; end
                    else begin req_addr1 = rand_addr(); req_wdata1 = $urandom; end
`ifdef DMEM_ARB_LOCK_EN
                    req_lock[i] = ($urandom_range(0, 2) == 0);
`endif
                end
            end
            reset = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
